// File: rtl/fx2_pkg.sv
// fx2_pkg: shared types and constants for the FX2LP slave-FIFO reader.
// Holds the read FSM state type, endpoint FIFOADR codes and word geometry.
package fx2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OE,
    STROBE,
    GAP
  } fx2_rd_state_e;

  localparam logic [1:0] FX2_EP2_ADDR = 2'b00;
  localparam logic [1:0] FX2_EP6_ADDR = 2'b10;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/fx2_fifo_reader_if.sv
// fx2_fifo_reader_if: FX2 pin bus plus the 32-bit valid/ready word stream.
// master = the reader, slave = FX2 endpoint and word consumer side.
interface fx2_fifo_reader_if;

  logic [7:0]  fd_i;
  logic        flagn_empty;
  logic        slrdn;
  logic        sloen;
  logic [1:0]  fifoadr;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    input  fd_i,
    input  flagn_empty,
    output slrdn,
    output sloen,
    output fifoadr,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    output fd_i,
    output flagn_empty,
    input  slrdn,
    input  sloen,
    input  fifoadr,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/fx2_word_buf.sv
// fx2_word_buf: DEPTH x 32 shift-register FIFO, registered head and valid.
// Entry 0 is always the head, so out_data comes straight from a flop.
module fx2_word_buf #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] in_data,
  output logic        full,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   q [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] widx;
  logic          pop;

  assign pop      = out_valid && out_ready;
  assign full     = (cnt == CW'(DEPTH));
  assign out_data = q[0];

  // Next fill level and the slot a push lands in after any shift.
  always_comb begin
    cnt_nxt = cnt + CW'(push) - CW'(pop);
    widx    = pop ? AW'(cnt - CW'(1)) : AW'(cnt);
  end

  // Shift on pop, write behind the last live entry on push.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (pop)
        for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
      if (push) q[widx] <= in_data;
      cnt       <= cnt_nxt;
      out_valid <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/fx2_fifo_reader.sv
// fx2_fifo_reader: FX2LP slave-FIFO OUT reader, 4 FD bytes -> one I/Q word.
// Define FX2_RD_UNDERRUN_CNT_EN to add the underrun_cnt port and counter.
module fx2_fifo_reader
  import fx2_pkg::*;
#(
  parameter logic [1:0] FIFO_ADDR = FX2_EP6_ADDR,
  parameter int         BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        iq_swap,
`ifdef FX2_RD_UNDERRUN_CNT_EN
  output logic [15:0] underrun_cnt,
`endif
  fx2_fifo_reader_if.master bus
);

  localparam int BW = $clog2(BYTES_PER_WORD);

  fx2_rd_state_e state;
  logic [BW-1:0] bcnt;
  logic [23:0]   lo_q;
  logic          slrdn_q;
  logic          sloen_q;
  logic          push;
  logic          full;
  logic          go;
  logic [31:0]   buf_data;
  logic          buf_valid;

  assign go   = en && !full;
  assign push = (state == STROBE) &&
                (bcnt == BW'(BYTES_PER_WORD - 1));

  // Strobe sequencer: one byte per STROBE, a GAP cycle between strobes.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state   <= IDLE;
      bcnt    <= '0;
      sloen_q <= 1'b1;
      slrdn_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            state   <= OE;
            sloen_q <= 1'b0;
          end
        end
        OE: begin
          if (bus.flagn_empty) begin
            state   <= STROBE;
            slrdn_q <= 1'b0;
          end else begin
            state <= GAP;
          end
        end
        STROBE: begin
          lo_q    <= {bus.fd_i, lo_q[23:8]};
          bcnt    <= bcnt + BW'(1);
          state   <= GAP;
          slrdn_q <= 1'b1;
        end
        GAP: begin
          if (bcnt != '0) begin
            if (bus.flagn_empty) begin
              state   <= STROBE;
              slrdn_q <= 1'b0;
            end
          end else if (!go) begin
            state   <= IDLE;
            sloen_q <= 1'b1;
          end else if (bus.flagn_empty) begin
            state   <= STROBE;
            slrdn_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          sloen_q <= 1'b1;
          slrdn_q <= 1'b1;
        end
      endcase
    end
  end

  fx2_word_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .in_data  ({bus.fd_i, lo_q}),
    .full     (full),
    .out_data (buf_data),
    .out_valid(buf_valid),
    .out_ready(bus.out_ready)
  );

  assign bus.slrdn     = slrdn_q;
  assign bus.sloen     = sloen_q;
  assign bus.fifoadr   = FIFO_ADDR;
  assign bus.out_valid = buf_valid;
  assign bus.out_data  = iq_swap ?
                         {buf_data[15:0], buf_data[31:16]} :
                         buf_data;

`ifdef FX2_RD_UNDERRUN_CNT_EN
  // Saturating count of cycles the consumer starves while enabled.
  always_ff @(posedge clk) begin
    if (reset || flush)
      underrun_cnt <= '0;
    else if (en && bus.out_ready && !buf_valid &&
             underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`else
  // Build without underrun tracking: no counter, no port.
`endif

endmodule

// File: tb/tb_fx2_fifo_reader.sv
// tb_fx2_fifo_reader: FX2 endpoint queue model + byte-to-word scoreboard.
// Define FX2_RD_UNDERRUN_CNT_EN to also check underrun_cnt.
module tb_fx2_fifo_reader;

  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  logic en;
  logic flush;
  logic iq_swap;
`ifdef FX2_RD_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  fx2_fifo_reader_if bus ();

  fx2_fifo_reader #(
    .FIFO_ADDR(2'b10),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .flush       (flush),
    .iq_swap     (iq_swap),
`ifdef FX2_RD_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ep_q [$];
  logic [7:0]  part [$];
  logic [31:0] exp_q [$];
  int          n_rd = 0;
  int          n_words = 0;
  logic [31:0] last_word = '0;
  logic        prev_stb = 1'b0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic drive_ep();
    bus.flagn_empty = (ep_q.size() != 0);
    bus.fd_i = (ep_q.size() != 0) ? ep_q[0] : 8'h00;
  endtask

  task automatic ep_load(logic [7:0] first, int n);
    for (int i = 0; i < n; i++) ep_q.push_back(first + 8'(i));
    drive_ep();
  endtask

  // One clock: observe at negedge, update endpoint + model at posedge.
  task automatic step();
    logic stb;
    logic hs;
    logic clr;
    logic [31:0] d;
    logic [31:0] w;
    @(negedge clk);
    stb = !bus.slrdn;
    hs  = bus.out_valid && bus.out_ready;
    d   = bus.out_data;
    clr = flush || reset;
    if (stb)
      chk("strobe_ok", {29'd0, bus.flagn_empty, bus.sloen, prev_stb},
          32'd4);
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("spurious_word", 32'd0, 32'd1);
      end else begin
        w = exp_q.pop_front();
        if (iq_swap) w = {w[15:0], w[31:16]};
        chk("word", d, w);
        last_word = d;
        n_words++;
      end
    end
    prev_stb = stb;
    @(posedge clk);
    if (stb) begin
      if (ep_q.size() != 0) part.push_back(ep_q.pop_front());
      else part.push_back(8'h00);
      n_rd++;
      if (part.size() == 4) begin
        exp_q.push_back({part[3], part[2], part[1], part[0]});
        part.delete();
      end
    end
    if (clr) begin
      part.delete();
      exp_q.delete();
    end
    #1;
    drive_ep();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    flush = 1'b0;
    iq_swap = 1'b0;
    bus.out_ready = 1'b0;
    ep_q.delete();
    drive_ep();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_rd(int target, int lim);
    int k = 0;
    while (n_rd < target && k < lim) begin
      step();
      k++;
    end
    if (n_rd < target) chk("timeout_rd", n_rd, target);
  endtask

  initial begin
    int c0;
    int c1;
    int base;
    int wbase;
    logic ok;
    int n;

    reset = 1'b1;
    en = 1'b0;
    flush = 1'b0;
    iq_swap = 1'b0;
    bus.out_ready = 1'b0;
    drive_ep();

    // Reset state.
    do_reset();
    chk("rst_slrdn", bus.slrdn, 1);
    chk("rst_sloen", bus.sloen, 1);
    chk("rst_fifoadr", bus.fifoadr, 2'b10);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);

    // First word latency and two words in order.
    wbase = n_words;
    ep_load(8'h01, 8);
    bus.out_ready = 1'b1;
    en = 1'b1;
    c0 = -1;
    c1 = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (c0 < 0 && !bus.sloen) c0 = i;
      if (c1 < 0 && bus.out_valid) c1 = i;
    end
    chk("first_latency", c1 - c0, 8);
    chk("first_words", n_words - wbase, 2);
    chk("first_last", last_word, 32'h08070605);
    en = 1'b0;
    repeat (6) step();
    chk("first_idle", bus.sloen, 1);

    // iq_swap at the output.
    do_reset();
    iq_swap = 1'b1;
    bus.out_ready = 1'b1;
    en = 1'b1;
    ep_load(8'h01, 4);
    repeat (20) step();
    chk("swap_word", last_word, 32'h02010403);
    en = 1'b0;
    repeat (6) step();

    // Mid-word stall on empty flag, then completion with en dropped.
    do_reset();
    bus.out_ready = 1'b1;
    en = 1'b1;
    base = n_rd;
    ep_q.push_back(8'h11);
    ep_q.push_back(8'h22);
    drive_ep();
    wait_rd(base + 2, 40);
    ok = 1'b1;
    repeat (10) begin
      step();
      if (bus.sloen || !bus.slrdn) ok = 1'b0;
    end
    chk("stall_gap", ok, 1);
    ep_q.push_back(8'h33);
    ep_q.push_back(8'h44);
    drive_ep();
    en = 1'b0;
    repeat (30) step();
    chk("stall_word", last_word, 32'h44332211);
    chk("stall_idle", bus.sloen, 1);

    // Backpressure: only DEPTH words read, then drained in order.
    do_reset();
    en = 1'b1;
    base = n_rd;
    wbase = n_words;
    ep_load(8'h40, 20);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (i >= 30 && !bus.slrdn) ok = 1'b1;
    end
    chk("bp_reads", n_rd - base, 4 * DEPTH);
    chk("bp_quiet", ok, 0);
    chk("bp_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    repeat (80) step();
    chk("bp_words", n_words - wbase, 5);
    chk("bp_last", last_word, 32'h53525150);
    en = 1'b0;
    repeat (6) step();

    // Flush after byte 1, then en=0 after byte 2 of the next word.
    do_reset();
    bus.out_ready = 1'b1;
    en = 1'b1;
    base = n_rd;
    wbase = n_words;
    ep_load(8'hA1, 9);
    wait_rd(base + 1, 20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_rd(base + 7, 60);
    en = 1'b0;
    repeat (30) step();
    chk("flush_words", n_words - wbase, 2);
    chk("flush_last", last_word, 32'hA9A8A7A6);
    chk("flush_left", ep_q.size(), 0);
    chk("flush_idle", bus.sloen, 1);

    // Randomized traffic against the scoreboard.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0)
        iq_swap = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) en = !en;
      flush = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(1, 6);
        for (int j = 0; j < n; j++)
          ep_q.push_back(8'($urandom));
        drive_ep();
      end
      step();
    end
    flush = 1'b0;
    en = 1'b0;
    bus.out_ready = 1'b1;
    ep_load(8'hE0, 8);
    repeat (80) step();
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_part", part.size(), 0);
    chk("rand_idle", bus.sloen, 1);

`ifdef FX2_RD_UNDERRUN_CNT_EN
    do_reset();
    chk("uc_reset", underrun_cnt, 0);
    en = 1'b1;
    bus.out_ready = 1'b1;
    repeat (20) step();
    chk("uc_count", underrun_cnt, 20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("uc_flush", underrun_cnt, 0);
`else
    en = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
